// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with per-entry saturating counters, optional gshare indexing,
// global branch history and saturating performance counters. Lookup is combinational.
module branch_predictor_unit #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int GSHARE     = 0,
    parameter int HIST_BITS  = 4,
    parameter int STAT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 pred_taken,
    output logic                 pred_hit,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_is_jump,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic [HIST_BITS-1:0] upd_hist,
    input  logic                 upd_mispredict,
    output logic [STAT_W-1:0]    stat_branches,
    output logic [STAT_W-1:0]    stat_mispred
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

    logic [ENTRIES-1:0]   valid_q;
    logic [WORD_SIZE-1:0] tag_q [ENTRIES];
    logic [WORD_SIZE-1:0] tgt_q [ENTRIES];
    logic [ENTRIES-1:0]   jmp_q;
    logic [CTR_BITS-1:0]  ctr_q [ENTRIES];
    logic [HIST_BITS-1:0] hist_q, hist_d;
    logic [STAT_W-1:0]    br_q, br_d, mis_q, mis_d;

    logic [INDEX_BITS-1:0] lk_idx, up_idx;
    logic                  up_hit, up_tkn, wr_en;
    logic [CTR_BITS-1:0]   ctr_d;
    logic [WORD_SIZE-1:0]  tgt_d;

    // History is zero-extended into the XOR; GSHARE=0 masks it out entirely.
    assign lk_idx = if_pc[INDEX_BITS-1:0]  ^ ((GSHARE != 0) ? INDEX_BITS'(hist_q)   : '0);
    assign up_idx = upd_pc[INDEX_BITS-1:0] ^ ((GSHARE != 0) ? INDEX_BITS'(upd_hist) : '0);

    assign pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == if_pc);
    assign pred_taken = pred_hit && (jmp_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);
    assign pred_pc    = pred_taken ? tgt_q[lk_idx] : if_pc + WORD_SIZE'(1);
    assign pred_hist  = (GSHARE != 0) ? hist_q : '0;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == upd_pc);
    assign up_tkn = upd_is_jump || upd_taken;
    assign wr_en  = upd_valid && (up_hit || up_tkn);
    assign tgt_d  = up_tkn ? upd_target : tgt_q[up_idx];

    always_comb begin
        ctr_d = ctr_q[up_idx];
        if (!up_hit) begin
            ctr_d = CTR_WT;
        end else if (!upd_is_jump) begin
            if (upd_taken && ctr_q[up_idx] != CTR_MAX)
                ctr_d = ctr_q[up_idx] + CTR_BITS'(1);
            else if (!upd_taken && ctr_q[up_idx] != '0)
                ctr_d = ctr_q[up_idx] - CTR_BITS'(1);
        end
    end

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign hist_d = upd_taken;
        end else begin : g_histn
            assign hist_d = {hist_q[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    assign br_d  = (&br_q)  ? br_q  : br_q  + STAT_W'(1);
    assign mis_d = (&mis_q) ? mis_q : mis_q + STAT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
            hist_q  <= '0;
            br_q    <= '0;
            mis_q   <= '0;
        end else if (upd_valid) begin
            if (wr_en) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= ctr_d;
            end
            if (!upd_is_jump) hist_q <= hist_d;
            br_q <= br_d;
            if (upd_mispredict) mis_q <= mis_d;
        end
    end

    // Payload fields need no reset: they are only observed behind valid_q.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            tag_q[up_idx] <= upd_pc;
            tgt_q[up_idx] <= tgt_d;
            jmp_q[up_idx] <= upd_is_jump;
        end
    end

    assign stat_branches = br_q;
    assign stat_mispred  = mis_q;
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: a default instance and a gshare/2-bit-stat instance
// share stimulus; expected lookups are queued at drive time and popped at the negedge.
module tb_branch_predictor_unit;
    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [15:0] pc;
        logic [3:0]  hist;
    } look_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] if_pc = '0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic [3:0]  upd_hist = '0;
    logic        upd_mispredict = 1'b0;

    logic [15:0] p0_pc, p1_pc;
    logic        p0_taken, p1_taken, p0_hit, p1_hit;
    logic [3:0]  p0_hist, p1_hist;
    logic [15:0] s0_br, s0_mis;
    logic [1:0]  s1_br, s1_mis;

    look_t obs0, obs1, e;
    look_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    assign obs0 = {p0_hit, p0_taken, p0_pc, p0_hist};
    assign obs1 = {p1_hit, p1_taken, p1_pc, p1_hist};

    always #5 clk = ~clk;

    branch_predictor_unit u0 (
        .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
        .pred_pc(p0_pc), .pred_taken(p0_taken), .pred_hit(p0_hit), .pred_hist(p0_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_hist(upd_hist),
        .upd_mispredict(upd_mispredict), .stat_branches(s0_br), .stat_mispred(s0_mis)
    );

    branch_predictor_unit #(.GSHARE(1), .STAT_W(2)) u1 (
        .clk(clk), .reset_n(reset_n), .if_pc(if_pc),
        .pred_pc(p1_pc), .pred_taken(p1_taken), .pred_hit(p1_hit), .pred_hist(p1_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_hist(upd_hist),
        .upd_mispredict(upd_mispredict), .stat_branches(s1_br), .stat_mispred(s1_mis)
    );

    task automatic do_upd(input logic [15:0] pc, input logic jmp, input logic tkn,
                          input logic [15:0] tgt, input logic [3:0] h, input logic mis);
        upd_pc = pc; upd_is_jump = jmp; upd_taken = tkn; upd_target = tgt;
        upd_hist = h; upd_mispredict = mis; upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] st [4];
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        if_pc = 16'h0010;
        exp_q.push_back('{1'b0, 1'b0, 16'h0011, 4'h0});
        exp_q.push_back('{1'b0, 1'b0, 16'h0011, 4'h0});
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (obs0 !== e) begin n_err++; $display("FAIL reset_look0 got=%h exp=%h", obs0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (obs1 !== e) begin n_err++; $display("FAIL reset_look1 got=%h exp=%h", obs1, e); end
        st = '{s0_br, s0_mis, 16'(s1_br), 16'(s1_mis)};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (st[i] !== 16'h0) begin n_err++; $display("FAIL reset_stat%0d got=%h exp=0", i, st[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_jump();
        do_upd(16'h0010, 1'b1, 1'b0, 16'h0040, 4'h0, 1'b1);
        if_pc = 16'h0010;
        exp_q.push_back('{1'b1, 1'b1, 16'h0040, 4'h0});
        exp_q.push_back('{1'b1, 1'b1, 16'h0040, 4'h0});
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (obs0 !== e) begin n_err++; $display("FAIL jump_look0 got=%h exp=%h", obs0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (obs1 !== e) begin n_err++; $display("FAIL jump_look1 got=%h exp=%h", obs1, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_counter();
        logic tk [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   ctr = 1;
        bit   alloc = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_upd(16'h0005, 1'b0, tk[i], 16'h0020, 4'h0, 1'b0);
            if (!alloc) begin ctr = 2; alloc = 1'b1; end
            else if (tk[i]) ctr = (ctr == 3) ? 3 : ctr + 1;
            else            ctr = (ctr == 0) ? 0 : ctr - 1;
            if_pc = 16'h0005;
            exp_q.push_back('{1'b1, ctr >= 2, (ctr >= 2) ? 16'h0020 : 16'h0006, 4'h0});
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs0 !== e) begin n_err++; $display("FAIL ctr_step%0d got=%h exp=%h", i, obs0, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alias();
        logic [15:0] lpc [3] = '{16'h0003, 16'h0003, 16'h0013};
        do_reset();
        do_upd(16'h0003, 1'b0, 1'b1, 16'h0030, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) do_upd(16'h0013, 1'b0, 1'b1, 16'h0050, 4'h0, 1'b0);
            if_pc = lpc[i];
            case (i)
                0:       exp_q.push_back('{1'b1, 1'b1, 16'h0030, 4'h0});
                1:       exp_q.push_back('{1'b0, 1'b0, 16'h0004, 4'h0});
                default: exp_q.push_back('{1'b1, 1'b1, 16'h0050, 4'h0});
            endcase
            @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (obs0 !== e) begin n_err++; $display("FAIL alias_look%0d got=%h exp=%h", i, obs0, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_gshare();
        logic       seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] h = 4'h0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_upd(16'h0100, 1'b0, seq[i], 16'h0200, h, 1'b0);
            h = {h[2:0], seq[i]};
        end
        if_pc = 16'h0100;
        exp_q.push_back('{1'b0, 1'b0, 16'h0101, 4'b1101});
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (obs1 !== e) begin n_err++; $display("FAIL gshare_hist got=%h exp=%h", obs1, e); end
        @(posedge clk); #1;
        // Jump update to idx 2^hist while the same index is looked up.
        upd_pc = 16'h0002; upd_is_jump = 1'b1; upd_taken = 1'b0; upd_target = 16'h0077;
        upd_hist = h; upd_mispredict = 1'b0; upd_valid = 1'b1;
        if_pc = 16'h0002;
        exp_q.push_back('{1'b0, 1'b0, 16'h0003, h});
        exp_q.push_back('{1'b1, 1'b1, 16'h0077, h});
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (obs1 !== e) begin n_err++; $display("FAIL gshare_same_cycle got=%h exp=%h", obs1, e); end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (obs1 !== e) begin n_err++; $display("FAIL gshare_next_cycle got=%h exp=%h", obs1, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_stats();
        int br = 0, mis = 0;
        logic [15:0] got [4];
        logic [15:0] ex  [4];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_upd(16'h0008, 1'b0, 1'b0, 16'h0088, 4'h0, i != 0);
            br++;
            if (i != 0) mis++;
        end
        @(negedge clk);
        got = '{s0_br, s0_mis, 16'(s1_br), 16'(s1_mis)};
        ex  = '{16'(br), 16'(mis), 16'((br > 3) ? 3 : br), 16'((mis > 3) ? 3 : mis)};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== ex[i]) begin n_err++; $display("FAIL stat%0d got=%0d exp=%0d", i, got[i], ex[i]); end
        end
        @(posedge clk); #1;
        // Reset with an update pending: update must be dropped.
        upd_pc = 16'h0009; upd_is_jump = 1'b1; upd_target = 16'h0099;
        upd_hist = 4'h0; upd_mispredict = 1'b1; upd_valid = 1'b1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; upd_valid = 1'b0;
        if_pc = 16'h0009;
        exp_q.push_back('{1'b0, 1'b0, 16'h000a, 4'h0});
        exp_q.push_back('{1'b0, 1'b0, 16'h000a, 4'h0});
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (obs0 !== e) begin n_err++; $display("FAIL rst_upd_look0 got=%h exp=%h", obs0, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (obs1 !== e) begin n_err++; $display("FAIL rst_upd_look1 got=%h exp=%h", obs1, e); end
        got = '{s0_br, s0_mis, 16'(s1_br), 16'(s1_mis)};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== 16'h0) begin n_err++; $display("FAIL rst_upd_stat%0d got=%0d exp=0", i, got[i]); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_counter();
        test_alias();
        test_gshare();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
